// File: rtl/vga_timing_pkg.sv
// Video mode table and helpers shared by the timing generator and its delay line.
package vga_timing_pkg;

    typedef struct packed {
        logic [11:0] h_act;
        logic [11:0] h_fp;
        logic [11:0] h_sync;
        logic [11:0] h_bp;
        logic [10:0] v_act;
        logic [10:0] v_fp;
        logic [10:0] v_sync;
        logic [10:0] v_bp;
        logic        h_pol;
        logic        v_pol;
    } vga_mode_t;

    // Entries 4..7 mirror mode 0 so an oversized NUM_MODES still yields a sane raster.
    localparam vga_mode_t MODE_TABLE [8] = '{
        '{12'd640, 12'd16, 12'd96,  12'd48, 11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0},
        '{12'd800, 12'd40, 12'd128, 12'd88, 11'd600, 11'd1,  11'd4, 11'd23, 1'b1, 1'b1},
        '{12'd640, 12'd16, 12'd96,  12'd48, 11'd400, 11'd12, 11'd2, 11'd35, 1'b0, 1'b1},
        '{12'd320, 12'd8,  12'd16,  12'd16, 11'd240, 11'd2,  11'd2, 11'd4,  1'b0, 1'b0},
        '{12'd640, 12'd16, 12'd96,  12'd48, 11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0},
        '{12'd640, 12'd16, 12'd96,  12'd48, 11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0},
        '{12'd640, 12'd16, 12'd96,  12'd48, 11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0},
        '{12'd640, 12'd16, 12'd96,  12'd48, 11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0}
    };

    function automatic logic [15:0] mode_total_h(input vga_mode_t m);
        return 16'(m.h_act) + 16'(m.h_fp) + 16'(m.h_sync) + 16'(m.h_bp);
    endfunction

    function automatic logic [15:0] mode_total_v(input vga_mode_t m);
        return 16'(m.v_act) + 16'(m.v_fp) + 16'(m.v_sync) + 16'(m.v_bp);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-tick gated shift register that aligns sync/active with the pixel pipeline.
module vga_sync_delay #(
    parameter int W   = 3,
    parameter int DLY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (DLY == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{clk, rst_n, clk_en, rst_val};
        assign dout = din;
    end else begin : g_shift
        logic [W-1:0] sr [DLY];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < DLY; i++) sr[i] <= rst_val;
            end else if (clk_en) begin
                sr[0] <= din;
                for (int i = 1; i < DLY; i++) sr[i] <= sr[i-1];
            end
        end

        assign dout = sr[DLY-1];
    end

endmodule

// File: rtl/vga_timing_multi.sv
// Multi-mode raster timing generator; mode switches only at the frame wrap.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_multi
    import vga_timing_pkg::*;
#(
    parameter int NUM_MODES = 4,
    parameter int DEF_MODE  = 0,
    parameter int PIPE_DLY  = 2,
    parameter int HW        = 11,
    parameter int VW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic [2:0]    mode_sel,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          fetch_act,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          h_begin,
    output logic          v_begin,
    output logic [2:0]    cur_mode,
    output logic [15:0]   frame_cnt
);

    localparam vga_mode_t DEF_M = MODE_TABLE[DEF_MODE];
    // Delay line powers up carrying "not active, sync deasserted" for the reset mode.
    localparam logic [2:0] DLY_RST = {1'b0, ~DEF_M.h_pol, ~DEF_M.v_pol};

    vga_mode_t     m;
    logic [HW-1:0] h_last_pos, hs_start, hs_end;
    logic [VW-1:0] v_last_pos, vs_start, vs_end, v_next;
    logic          h_last, v_last, mode_ok, hs_u, vs_u;

    assign m          = MODE_TABLE[cur_mode];
    assign h_last_pos = HW'(mode_total_h(m) - 16'd1);
    assign v_last_pos = VW'(mode_total_v(m) - 16'd1);
    assign hs_start   = HW'(m.h_act + m.h_fp);
    assign hs_end     = HW'(m.h_act + m.h_fp + m.h_sync);
    assign vs_start   = VW'(m.v_act + m.v_fp);
    assign vs_end     = VW'(m.v_act + m.v_fp + m.v_sync);

    assign h_last  = (hpos == h_last_pos);
    assign v_last  = (vpos == v_last_pos);
    assign mode_ok = (32'(mode_sel) < NUM_MODES);

    assign fetch_act = (hpos < HW'(m.h_act)) && (vpos < VW'(m.v_act));
    assign hs_u      = ((hpos >= hs_start) && (hpos < hs_end)) ? m.h_pol : ~m.h_pol;
    assign vs_u      = ((vpos >= vs_start) && (vpos < vs_end)) ? m.v_pol : ~m.v_pol;

    assign v_next  = v_last ? '0 : vpos + 1'b1;
    assign h_begin = clk_en && h_last && (v_next < VW'(m.v_act));
    assign v_begin = clk_en && h_last && v_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos     <= '0;
            vpos     <= '0;
            cur_mode <= 3'(DEF_MODE);
        end else if (clk_en) begin
            if (h_last) begin
                hpos <= '0;
                if (v_last) begin
                    vpos <= '0;
                    if (mode_ok) cur_mode <= mode_sel;
                end else begin
                    vpos <= vpos + 1'b1;
                end
            end else begin
                hpos <= hpos + 1'b1;
            end
        end
    end

    vga_sync_delay #(
        .W   (3),
        .DLY (PIPE_DLY)
    ) u_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .rst_val (DLY_RST),
        .din     ({fetch_act, hs_u, vs_u}),
        .dout    ({active, hsync, vsync})
    );

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)       frame_cnt_q <= '0;
        else if (v_begin) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_vga_timing_multi.sv
// Randomized bench: three generator instances checked each cycle against a raster model.
module tb_vga_timing_multi;

    localparam int NI = 3;
    localparam int EW = 46;
    localparam int DEFS [NI] = '{3, 3, 0};
    localparam int DLYS [NI] = '{0, 2, 2};

    // Mode timings: active, front porch, sync, back porch, polarity.
    int t_ha [4] = '{640, 800, 640, 320};
    int t_hf [4] = '{16, 40, 16, 8};
    int t_hs [4] = '{96, 128, 96, 16};
    int t_hb [4] = '{48, 88, 48, 16};
    int t_va [4] = '{480, 600, 400, 240};
    int t_vf [4] = '{10, 1, 12, 2};
    int t_vs [4] = '{2, 4, 2, 2};
    int t_vb [4] = '{33, 23, 35, 4};
    bit t_hp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit t_vp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    logic        clk;
    logic        clk_en;
    logic [2:0]  rstn_v;
    logic [2:0]  msel    [NI];
    logic [2:0]  nxt_sel [NI];
    logic [10:0] hpos_o  [NI];
    logic [9:0]  vpos_o  [NI];
    logic        fa_o    [NI];
    logic        act_o   [NI];
    logic        hs_o    [NI];
    logic        vs_o    [NI];
    logic        hb_o    [NI];
    logic        vb_o    [NI];
    logic [2:0]  cur_o   [NI];
    logic [15:0] fc_o    [NI];

    logic [NI*EW-1:0] exp_q [$];
    logic [NI*EW-1:0] got_v, exp_v;

    int   mx [NI], my [NI], mm [NI], mfc [NI];
    logic [2:0] hist [NI][8];
    bit   primed = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   vb_cnt_a = 0;
    bit   c_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vga_timing_multi #(
            .NUM_MODES (4),
            .DEF_MODE  (DEFS[g]),
            .PIPE_DLY  (DLYS[g]),
            .HW        (11),
            .VW        (10)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rstn_v[g]),
            .clk_en    (clk_en),
            .mode_sel  (msel[g]),
            .hpos      (hpos_o[g]),
            .vpos      (vpos_o[g]),
            .fetch_act (fa_o[g]),
            .active    (act_o[g]),
            .hsync     (hs_o[g]),
            .vsync     (vs_o[g]),
            .h_begin   (hb_o[g]),
            .v_begin   (vb_o[g]),
            .cur_mode  (cur_o[g]),
            .frame_cnt (fc_o[g])
        );
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Predict this cycle's outputs from the model state, then advance the model by one clock.
    task automatic model_eval();
        logic [NI*EW-1:0] e;
        e = '0;
        for (int i = 0; i < NI; i++) begin
            int k, ht, vt, hss, hse, vss, vse, ny, d;
            logic fa, hu, vu, hb, vb;
            logic [2:0] dl;
            logic [15:0] fce;
            k   = mm[i];
            ht  = t_ha[k] + t_hf[k] + t_hs[k] + t_hb[k];
            vt  = t_va[k] + t_vf[k] + t_vs[k] + t_vb[k];
            hss = t_ha[k] + t_hf[k];
            hse = hss + t_hs[k];
            vss = t_va[k] + t_vf[k];
            vse = vss + t_vs[k];
            fa  = (mx[i] < t_ha[k]) && (my[i] < t_va[k]);
            hu  = (mx[i] >= hss && mx[i] < hse) ? t_hp[k] : !t_hp[k];
            vu  = (my[i] >= vss && my[i] < vse) ? t_vp[k] : !t_vp[k];
            ny  = (my[i] == vt - 1) ? 0 : my[i] + 1;
            hb  = clk_en && (mx[i] == ht - 1) && (ny < t_va[k]);
            vb  = clk_en && (mx[i] == ht - 1) && (my[i] == vt - 1);
            d   = DLYS[i];
            dl  = (d == 0) ? {fa, hu, vu} : hist[i][d-1];
`ifdef VGA_TIMING_FRAME_CNT_EN
            fce = 16'(mfc[i]);
`else
            fce = 16'h0;
`endif
            e[i*EW +: EW] = {11'(mx[i]), 10'(my[i]), 3'(mm[i]), fa, dl, hb, vb, fce};

            if (!rstn_v[i]) begin
                mx[i] = 0; my[i] = 0; mm[i] = DEFS[i]; mfc[i] = 0;
                for (int j = 0; j < 8; j++)
                    hist[i][j] = {1'b0, !t_hp[DEFS[i]], !t_vp[DEFS[i]]};
            end else if (clk_en) begin
                for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = {fa, hu, vu};
                if (vb) mfc[i] = (mfc[i] + 1) % 65536;
                if (mx[i] == ht - 1) begin
                    mx[i] = 0;
                    if (my[i] == vt - 1) begin
                        my[i] = 0;
                        if (int'(msel[i]) < 4) mm[i] = int'(msel[i]);
                    end else begin
                        my[i] = my[i] + 1;
                    end
                end else begin
                    mx[i] = mx[i] + 1;
                end
            end
        end
        if (primed) exp_q.push_back(e);
        primed = 1'b1;
    endtask

    task automatic cyc(input logic ce_v, input logic [2:0] rn);
        @(negedge clk);
        clk_en = ce_v;
        rstn_v = rn;
        for (int i = 0; i < NI; i++) msel[i] = nxt_sel[i];
        model_eval();
    endtask

    // Monitor: pops one expectation per cycle and compares every instance's outputs.
    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            for (int i = 0; i < NI; i++) begin
                got_v[i*EW +: EW] = {hpos_o[i], vpos_o[i], cur_o[i], fa_o[i], act_o[i],
                                     hs_o[i], vs_o[i], hb_o[i], vb_o[i], fc_o[i]};
                n_checks++;
                if (got_v[i*EW +: EW] === exp_v[i*EW +: EW]) n_pass++;
                else $display("FAIL dut%0d_outs t=%0t got=%h exp=%h", i, $time,
                              got_v[i*EW +: EW], exp_v[i*EW +: EW]);
            end
            if (vb_o[0] === 1'b1) vb_cnt_a++;
        end
    end

    initial begin
        logic [2:0] rn;
        clk_en = 1'b0;
        rstn_v = 3'b000;
        for (int i = 0; i < NI; i++) begin
            msel[i] = 3'd0;
            nxt_sel[i] = 3'd0;
        end

        for (int n = 0; n < 3; n++) cyc(1'($urandom_range(0, 1)), 3'b000);

        // One full mode-3 frame; a and b request 5 and 1 at the wrap, c resets mid-frame.
        for (int n = 0; n < 89290; n++) begin
            rn = 3'b111;
            if (my[0] >= 246) begin
                nxt_sel[0] = 3'd5;
                nxt_sel[1] = 3'd1;
            end else if ($urandom_range(0, 499) == 0) begin
                nxt_sel[0] = 3'($urandom_range(0, 7));
                nxt_sel[1] = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 499) == 0) nxt_sel[2] = 3'($urandom_range(0, 7));
            if (!c_done && mx[2] == 300 && my[2] == 20) begin
                rn[2] = 1'b0;
                c_done = 1'b1;
            end
            cyc(1'b1, rn);
        end
        #3;
        chk("a_mode_hold", int'(cur_o[0]), 3);
        chk("b_mode_switch", int'(cur_o[1]), 1);
        chk("a_vbegin_count", vb_cnt_a, 1);

        for (int n = 0; n < 2200; n++) begin
            if ($urandom_range(0, 99) == 0)
                for (int i = 0; i < NI; i++) nxt_sel[i] = 3'($urandom_range(0, 7));
            cyc(1'b1, 3'b111);
        end

        for (int n = 0; n < 1200; n++) cyc(1'((n % 4) == 0), 3'b111);

        for (int n = 0; n < 600; n++) begin
            rn = 3'b111;
            if (n == 300 || n == 301) rn[1] = 1'b0;
            if (n == 310) rn[2] = 1'b0;
            cyc(1'($urandom_range(0, 1)), rn);
        end

        for (int n = 0; n < 4; n++) cyc(1'b1, 3'b111);
        #3;
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
